hpdcache_wbuf_dir_ctrl: RTL and testbench

- Parametrised write-buffer directory controller for the HPDcache.
- Tracks up to WBUF_DIR_ENTRIES in-flight write-through lines.
- Coalesces writes to the same line, ages open entries against a run-time threshold, and arbitrates ready entries to the memory write interface.
- Retires entries on memory acknowledgement. Sits between the cache controller and the memory write channel; the data array is external and indexed by write_idx_o/send_idx_o.

---
 rtl/hpdcache_wbuf_dir_ctrl.sv | 179 +++++++++++++++++
 tb/tb_hpdcache_wbuf_dir_ctrl.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hpdcache_wbuf_dir_ctrl.sv
// Write-buffer directory controller: tracks in-flight write-through lines,
// coalesces same-line writes, ages open entries and offers them round-robin.
module hpdcache_wbuf_dir_ctrl #(
    parameter int unsigned WBUF_DIR_ENTRIES   = 16,
    parameter int unsigned WBUF_TIMECNT_WIDTH = 4,
    parameter int unsigned WBUF_TAG_WIDTH     = 43
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic [WBUF_TIMECNT_WIDTH-1:0]       cfg_threshold_i,
    input  logic                                cfg_reset_timecnt_on_write_i,
    input  logic                                write_valid_i,
    output logic                                write_ready_o,
    input  logic [WBUF_TAG_WIDTH-1:0]           write_tag_i,
    output logic [$clog2(WBUF_DIR_ENTRIES)-1:0] write_idx_o,
    input  logic                                flush_all_i,
    input  logic [WBUF_TAG_WIDTH-1:0]           read_tag_i,
    output logic                                read_hit_o,
    output logic                                send_valid_o,
    input  logic                                send_ready_i,
    output logic [$clog2(WBUF_DIR_ENTRIES)-1:0] send_idx_o,
    output logic [WBUF_TAG_WIDTH-1:0]           send_tag_o,
    input  logic                                ack_valid_i,
    input  logic [$clog2(WBUF_DIR_ENTRIES)-1:0] ack_idx_i,
    output logic                                empty_o,
    output logic                                full_o
);
    localparam int unsigned IDX_W = $clog2(WBUF_DIR_ENTRIES);

    typedef logic [IDX_W-1:0]              idx_t;
    typedef logic [WBUF_TIMECNT_WIDTH-1:0] age_t;
    typedef logic [WBUF_TAG_WIDTH-1:0]     tag_t;
    typedef enum logic [1:0] {ST_FREE, ST_OPEN, ST_PEND, ST_SENT} entry_state_e;

    entry_state_e state_q [WBUF_DIR_ENTRIES];
    entry_state_e state_d [WBUF_DIR_ENTRIES];
    tag_t         tag_q   [WBUF_DIR_ENTRIES];
    tag_t         tag_d   [WBUF_DIR_ENTRIES];
    age_t         age_q   [WBUF_DIR_ENTRIES];
    age_t         age_d   [WBUF_DIR_ENTRIES];
    idx_t         rr_ptr_q, rr_ptr_d;

    logic                        wr_hit, wr_free, wr_fire;
    idx_t                        wr_hit_idx, wr_free_idx;
    logic [WBUF_DIR_ENTRIES-1:0] send_elig;
    logic                        send_found, send_fire;
    idx_t                        send_sel, rr_cand;

    // Write path: coalesce into a matching OPEN entry, else take the lowest FREE one
    always_comb begin
        wr_hit      = 1'b0;
        wr_hit_idx  = '0;
        wr_free     = 1'b0;
        wr_free_idx = '0;
        for (int unsigned i = 0; i < WBUF_DIR_ENTRIES; i++) begin
            if (!wr_hit && state_q[i] == ST_OPEN && tag_q[i] == write_tag_i) begin
                wr_hit     = 1'b1;
                wr_hit_idx = idx_t'(i);
            end
            if (!wr_free && state_q[i] == ST_FREE) begin
                wr_free     = 1'b1;
                wr_free_idx = idx_t'(i);
            end
        end
        write_ready_o = wr_hit | wr_free;
        write_idx_o   = wr_hit ? wr_hit_idx : wr_free_idx;
        wr_fire       = write_valid_i & write_ready_o;
    end

    // A PEND entry waits while an older write to the same line is still in flight
    always_comb begin
        send_elig = '0;
        for (int unsigned i = 0; i < WBUF_DIR_ENTRIES; i++) begin
            send_elig[i] = (state_q[i] == ST_PEND);
            for (int unsigned j = 0; j < WBUF_DIR_ENTRIES; j++) begin
                if (state_q[j] == ST_SENT && tag_q[j] == tag_q[i]) begin
                    send_elig[i] = 1'b0;
                end
            end
        end
    end

    always_comb begin
        send_found = 1'b0;
        send_sel   = '0;
        rr_cand    = '0;
        for (int unsigned k = 0; k < WBUF_DIR_ENTRIES; k++) begin
            rr_cand = rr_ptr_q + idx_t'(k);
            if (!send_found && send_elig[rr_cand]) begin
                send_found = 1'b1;
                send_sel   = rr_cand;
            end
        end
        send_valid_o = send_found;
        send_idx_o   = send_sel;
        send_tag_o   = tag_q[send_sel];
        send_fire    = send_found & send_ready_i;
        rr_ptr_d     = send_fire ? send_sel + idx_t'(1) : rr_ptr_q;
    end

    always_comb begin
        empty_o    = 1'b1;
        full_o     = 1'b1;
        read_hit_o = 1'b0;
        for (int unsigned i = 0; i < WBUF_DIR_ENTRIES; i++) begin
            if (state_q[i] == ST_FREE) begin
                full_o = 1'b0;
            end else begin
                empty_o = 1'b0;
                if (tag_q[i] == read_tag_i) begin
                    read_hit_o = 1'b1;
                end
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < WBUF_DIR_ENTRIES; i++) begin
            state_d[i] = state_q[i];
            tag_d[i]   = tag_q[i];
            age_d[i]   = age_q[i];
            case (state_q[i])
                ST_FREE: begin
                    if (wr_fire && !wr_hit && wr_free_idx == idx_t'(i)) begin
                        state_d[i] = ST_OPEN;
                        tag_d[i]   = write_tag_i;
                        age_d[i]   = '0;
                    end
                end
                ST_OPEN: begin
                    if (age_q[i] != '1) begin
                        age_d[i] = age_q[i] + age_t'(1);
                    end
                    // A coalescing write keeps the entry open; closure is retried next cycle
                    if (wr_fire && wr_hit && wr_hit_idx == idx_t'(i)) begin
                        if (cfg_reset_timecnt_on_write_i) begin
                            age_d[i] = '0;
                        end
                    end else if (flush_all_i || age_q[i] >= cfg_threshold_i) begin
                        state_d[i] = ST_PEND;
                    end
                end
                ST_PEND: begin
                    if (send_fire && send_sel == idx_t'(i)) begin
                        state_d[i] = ST_SENT;
                    end
                end
                ST_SENT: begin
                    if (ack_valid_i && ack_idx_i == idx_t'(i)) begin
                        state_d[i] = ST_FREE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < WBUF_DIR_ENTRIES; i++) begin
                state_q[i] <= ST_FREE;
                tag_q[i]   <= '0;
                age_q[i]   <= '0;
            end
            rr_ptr_q <= '0;
        end else begin
            for (int unsigned i = 0; i < WBUF_DIR_ENTRIES; i++) begin
                state_q[i] <= state_d[i];
                tag_q[i]   <= tag_d[i];
                age_q[i]   <= age_d[i];
            end
            rr_ptr_q <= rr_ptr_d;
        end
    end

    ack_targets_sent_entry: assert property (
        @(posedge clk_i) disable iff (rst_i) ack_valid_i |-> state_q[ack_idx_i] == ST_SENT);

endmodule

// File: tb/tb_hpdcache_wbuf_dir_ctrl.sv
// Directed bench for hpdcache_wbuf_dir_ctrl: a fill-to-full vector table plus
// hand-written sequences for ageing, coalescing, WAW blocking, round-robin and reset.
module tb_hpdcache_wbuf_dir_ctrl;
    localparam int unsigned N  = 16;
    localparam int unsigned TW = 4;
    localparam int unsigned GW = 43;
    localparam int unsigned IW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [TW-1:0] thr = '0;
    logic          rst_tc = 1'b0;
    logic          wv = 1'b0;
    logic          wr_rdy;
    logic [GW-1:0] wtag = '0;
    logic [IW-1:0] widx;
    logic          flush = 1'b0;
    logic [GW-1:0] rtag = '0;
    logic          hit;
    logic          sv;
    logic          srdy = 1'b0;
    logic [IW-1:0] sidx;
    logic [GW-1:0] stag;
    logic          av = 1'b0;
    logic [IW-1:0] aidx = '0;
    logic          empty;
    logic          full;

    always #5 clk = ~clk;

    hpdcache_wbuf_dir_ctrl #(
        .WBUF_DIR_ENTRIES  (N),
        .WBUF_TIMECNT_WIDTH(TW),
        .WBUF_TAG_WIDTH    (GW)
    ) dut (
        .clk_i                       (clk),
        .rst_i                       (rst),
        .cfg_threshold_i             (thr),
        .cfg_reset_timecnt_on_write_i(rst_tc),
        .write_valid_i               (wv),
        .write_ready_o               (wr_rdy),
        .write_tag_i                 (wtag),
        .write_idx_o                 (widx),
        .flush_all_i                 (flush),
        .read_tag_i                  (rtag),
        .read_hit_o                  (hit),
        .send_valid_o                (sv),
        .send_ready_i                (srdy),
        .send_idx_o                  (sidx),
        .send_tag_o                  (stag),
        .ack_valid_i                 (av),
        .ack_idx_i                   (aidx),
        .empty_o                     (empty),
        .full_o                      (full)
    );

    typedef struct {
        logic          wv;
        logic [GW-1:0] wtag;
        logic [GW-1:0] rtag;
        logic          e_ready;
        logic [IW-1:0] e_widx;
        logic          e_full;
        logic          e_empty;
        logic          e_sv;
        logic [IW-1:0] e_sidx;
        logic          e_hit;
    } vec_t;

    vec_t vecs [18];

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        wv    = 1'b0;
        wtag  = '0;
        flush = 1'b0;
        rtag  = '0;
        srdy  = 1'b0;
        av    = 1'b0;
        aidx  = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        // Fill table: 16 distinct allocations, a rejected 17th, then a coalesce into entry 3
        for (int i = 0; i < 16; i++) begin
            vecs[i].wv      = 1'b1;
            vecs[i].wtag    = GW'(i);
            vecs[i].rtag    = (i == 0) ? GW'(0) : GW'(i - 1);
            vecs[i].e_ready = 1'b1;
            vecs[i].e_widx  = IW'(i);
            vecs[i].e_full  = 1'b0;
            vecs[i].e_empty = (i == 0);
            vecs[i].e_sv    = 1'b0;
            vecs[i].e_sidx  = '0;
            vecs[i].e_hit   = (i != 0);
        end
        vecs[16] = '{wv: 1'b1, wtag: GW'('h55), rtag: GW'('h55), e_ready: 1'b0, e_widx: '0,
                     e_full: 1'b1, e_empty: 1'b0, e_sv: 1'b0, e_sidx: '0, e_hit: 1'b0};
        vecs[17] = '{wv: 1'b1, wtag: GW'('h3), rtag: GW'('hF), e_ready: 1'b1, e_widx: IW'(3),
                     e_full: 1'b1, e_empty: 1'b0, e_sv: 1'b1, e_sidx: '0, e_hit: 1'b1};

        // Reset state
        do_reset();
        #1;
        chk("rst_ready", wr_rdy, 1);
        chk("rst_sv", sv, 0);
        chk("rst_hit", hit, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_widx", widx, 0);
        chk("rst_sidx", sidx, 0);

        // Basic: allocate, age to PEND, send, ack
        thr = 4'd3;
        rst_tc = 1'b0;
        wv = 1'b1; wtag = GW'('h10);
        #1;
        chk("a_widx", widx, 0);
        chk("a_ready", wr_rdy, 1);
        step();
        wv = 1'b0;
        #1;
        chk("a_sv_age0", sv, 0);
        for (int c = 1; c <= 3; c++) begin
            step();
            chk($sformatf("a_sv_age%0d", c), sv, 0);
        end
        step();
        chk("a_sv_pend", sv, 1);
        chk("a_stag", stag, 'h10);
        chk("a_sidx", sidx, 0);
        srdy = 1'b1;
        step();
        srdy = 1'b0; rtag = GW'('h10);
        #1;
        chk("a_sv_sent", sv, 0);
        chk("a_empty_sent", empty, 0);
        chk("a_hit_sent", hit, 1);
        av = 1'b1; aidx = '0;
        step();
        av = 1'b0;
        #1;
        chk("a_empty_ack", empty, 1);

        // Coalescing with age reset
        do_reset();
        thr = 4'd4; rst_tc = 1'b1;
        wv = 1'b1; wtag = GW'('h20);
        #1;
        chk("b_widx1", widx, 0);
        step();
        wv = 1'b0;
        step();
        wv = 1'b1; wtag = GW'('h20);
        #1;
        chk("b_widx2", widx, 0);
        chk("b_ready2", wr_rdy, 1);
        step();
        wv = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            step();
            chk($sformatf("b_sv_wait%0d", c), sv, 0);
        end
        step();
        chk("b_sv_pend", sv, 1);
        chk("b_stag", stag, 'h20);
        srdy = 1'b1;
        step();
        srdy = 1'b0;
        #1;
        chk("b_single_send", sv, 0);
        av = 1'b1; aidx = '0;
        step();
        av = 1'b0;
        #1;
        chk("b_empty", empty, 1);

        // Threshold 0 and coalesce-beats-closure (by age and by flush)
        do_reset();
        thr = 4'd0; rst_tc = 1'b1;
        wv = 1'b1; wtag = GW'('h70);
        step();
        #1;
        chk("f_coal_idx", widx, 0);
        step();
        wv = 1'b0;
        #1;
        chk("f_open_after_coal", sv, 0);
        step();
        chk("f_pend_thr0", sv, 1);
        do_reset();
        thr = 4'd15;
        wv = 1'b1; wtag = GW'('h71);
        step();
        flush = 1'b1;
        step();
        wv = 1'b0; flush = 1'b0;
        #1;
        chk("f_flush_coal_open", sv, 0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        #1;
        chk("f_flush_pend", sv, 1);

        // WAW: same-line PEND entry held back while an older one is SENT
        do_reset();
        thr = 4'd15; rst_tc = 1'b0;
        wv = 1'b1; wtag = GW'('h40);
        step();
        wv = 1'b0; flush = 1'b1;
        step();
        flush = 1'b0;
        #1;
        chk("c_sv0", sv, 1);
        chk("c_sidx0", sidx, 0);
        srdy = 1'b1;
        step();
        srdy = 1'b0; wv = 1'b1; wtag = GW'('h40);
        #1;
        chk("c_widx_new", widx, 1);
        step();
        wv = 1'b0; flush = 1'b1;
        step();
        flush = 1'b0; rtag = GW'('h40);
        #1;
        chk("c_blocked", sv, 0);
        chk("c_hit", hit, 1);
        av = 1'b1; aidx = '0;
        step();
        av = 1'b0;
        #1;
        chk("c_unblocked", sv, 1);
        chk("c_sidx1", sidx, 1);
        chk("c_stag", stag, 'h40);

        // Round-robin
        do_reset();
        thr = 4'd15;
        for (int i = 0; i < 3; i++) begin
            wv = 1'b1; wtag = GW'('hA0 + i);
            step();
        end
        wv = 1'b0; flush = 1'b1;
        step();
        flush = 1'b0; srdy = 1'b1;
        #1;
        chk("d_first", sidx, 0);
        step();
        chk("d_second", sidx, 1);
        step();
        chk("d_third", sidx, 2);
        step();
        srdy = 1'b0;
        #1;
        chk("d_drained", sv, 0);
        for (int i = 0; i < 3; i++) begin
            av = 1'b1; aidx = IW'(i);
            step();
        end
        av = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wv = 1'b1; wtag = GW'('hB0 + i);
            #1;
            chk($sformatf("d_alloc%0d", i), widx, i);
            step();
        end
        wv = 1'b0; flush = 1'b1;
        step();
        flush = 1'b0;
        #1;
        chk("d_ptr3_first", sidx, 3);
        srdy = 1'b1;
        step();
        chk("d_wrap_to0", sidx, 0);
        // Same-cycle send of 0, ack of 3 and allocation of 4
        av = 1'b1; aidx = IW'(3); wv = 1'b1; wtag = GW'('hC0);
        #1;
        chk("d_same_widx", widx, 4);
        step();
        srdy = 1'b0; av = 1'b0; wv = 1'b0; rtag = GW'('hC0);
        #1;
        chk("d_same_sidx", sidx, 1);
        chk("d_same_hit_new", hit, 1);
        rtag = GW'('hB3);
        #1;
        chk("d_same_acked", hit, 0);

        // Fill table
        do_reset();
        thr = 4'd15; rst_tc = 1'b0;
        for (int i = 0; i < 18; i++) begin
            wv = vecs[i].wv; wtag = vecs[i].wtag; rtag = vecs[i].rtag;
            #1;
            chk($sformatf("v%0d_ready", i), wr_rdy, vecs[i].e_ready);
            chk($sformatf("v%0d_widx", i), widx, vecs[i].e_widx);
            chk($sformatf("v%0d_full", i), full, vecs[i].e_full);
            chk($sformatf("v%0d_empty", i), empty, vecs[i].e_empty);
            chk($sformatf("v%0d_sv", i), sv, vecs[i].e_sv);
            chk($sformatf("v%0d_sidx", i), sidx, vecs[i].e_sidx);
            chk($sformatf("v%0d_hit", i), hit, vecs[i].e_hit);
            step();
        end
        wv = 1'b0;

        // Asynchronous reset with SENT entries outstanding
        do_reset();
        thr = 4'd15;
        for (int i = 0; i < 5; i++) begin
            wv = 1'b1; wtag = GW'('hE0 + i);
            step();
        end
        wv = 1'b0; flush = 1'b1;
        step();
        flush = 1'b0; srdy = 1'b1;
        repeat (5) step();
        srdy = 1'b0;
        #1;
        chk("e_all_sent", sv, 0);
        chk("e_not_empty", empty, 0);
        #1;
        rst = 1'b1;
        #1;
        chk("e_async_empty", empty, 1);
        chk("e_async_full", full, 0);
        rtag = GW'('hE2);
        #1;
        chk("e_async_hit", hit, 0);
        av = 1'b1; aidx = IW'(2);
        step();
        av = 1'b0; rst = 1'b0;
        step();
        #1;
        chk("e_stray_empty", empty, 1);
        wv = 1'b1; wtag = GW'('hE9);
        #1;
        chk("e_realloc_idx", widx, 0);
        wv = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
